// File: rtl/m_tstate_ring_counter.sv
// m_tstate_ring_counter
//   One-hot T-state ring for a microcoded CPU sequencer. All state changes
//   happen on the falling edge of iClk. The ring restarts at T1 when an
//   instruction ends (outside the fetch states), freezes permanently on a halt
//   until reset, and can be single-stepped on the rising edges of iStep.
//
// Ports
//   iClk       clock (state updates on negedge)
//   iReset     synchronous active-low reset, sampled on negedge
//   iEndCycle  current instruction complete -> restart at T1 (ignored in T1..T3)
//   iHalt      HLT decoded -> freeze ring, set oHalted
//   iStepMode  single-step mode: ring advances only on step pulses
//   iStep      step request level; a 0->1 transition is one advance
//   oT         one-hot T-state vector, bit 0 = T1
//   oFetch     registered, high in T1..T3
//   oHalted    high once a halt has been taken
//   oInstrCnt  completed-instruction count, wraps silently
module m_tstate_ring_counter #(
  parameter int unsigned pSTATES = 18,
  parameter int unsigned pCNT_W  = 16
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iEndCycle,
  input  logic              iHalt,
  input  logic              iStepMode,
  input  logic              iStep,
  output logic [pSTATES-1:0] oT,
  output logic              oFetch,
  output logic              oHalted,
  output logic [pCNT_W-1:0] oInstrCnt
);

  logic [pSTATES-1:0] t_q, t_d;
  logic               fetch_q, fetch_d;
  logic               halted_q, halted_d;
  logic [pCNT_W-1:0]  cnt_q, cnt_d;
  logic               step_prev_q;

  logic adv;
  logic in_fetch;
  logic at_last;

  // In step mode only the rising edge of iStep advances, so a held step
  // produces a single move.
  assign adv      = !iStepMode || (iStep && !step_prev_q);
  assign in_fetch = |t_q[2:0];
  assign at_last  = t_q[pSTATES-1];

  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (halted_q) begin
      // frozen until reset
    end else if (iHalt) begin
      halted_d = 1'b1;
    end else if (!adv) begin
      // hold
    end else if (iEndCycle && !in_fetch) begin
      // Covers the last state too: restart and wrap coincide, one increment.
      t_d   = {{(pSTATES-1){1'b0}}, 1'b1};
      cnt_d = cnt_q + pCNT_W'(1);
    end else begin
      t_d = {t_q[pSTATES-2:0], t_q[pSTATES-1]};
      if (at_last) begin
        cnt_d = cnt_q + pCNT_W'(1);
      end
    end
    fetch_d = |t_d[2:0];
  end

  always_ff @(negedge iClk) begin
    if (!iReset) begin
      t_q         <= {{(pSTATES-1){1'b0}}, 1'b1};
      fetch_q     <= 1'b1;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
    end else begin
      t_q         <= t_d;
      fetch_q     <= fetch_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
      step_prev_q <= iStep;
    end
  end

  assign oT        = t_q;
  assign oFetch    = fetch_q;
  assign oHalted   = halted_q;
  assign oInstrCnt = cnt_q;

endmodule
